// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: sequences divider reconfiguration (drain, update, resume/lock) around a registered enable.
// Optional build macro CLK_DIV_CTRL_SAME_SKIP_EN: a request matching the current config completes at once.
module clk_div_ctrl #(
    parameter int         SETTLE_CYCLES = 4,
    parameter int         LOCK_CYCLES   = 16,
    parameter logic [1:0] DEFAULT_SEL   = 2'b00
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       run,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic       req_bypass,
    output logic       div_enable,
    output logic [1:0] div_sel,
    output logic       div_bypass,
    output logic       busy,
    output logic       done
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] RESUME = 2'd3;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CYCLES - 1);

    logic [1:0] state, next_state;
    logic [7:0] cnt;
    logic [1:0] cap_sel;
    logic       cap_bypass;
    logic       accept, same;

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = req_valid && req_ready;
`ifdef CLK_DIV_CTRL_SAME_SKIP_EN
    assign same = req_sel == div_sel && req_bypass == div_bypass;
`else
    assign same = 1'b0;
`endif

    // Next-state: fixed dwell in DRAIN and RESUME, single cycle in UPDATE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (accept && !same) ? DRAIN : IDLE;
            DRAIN:   next_state = (cnt == SETTLE_LAST) ? UPDATE : DRAIN;
            UPDATE:  next_state = RESUME;
            RESUME:  next_state = (cnt == LOCK_LAST) ? IDLE : RESUME;
        endcase
    end

    // State, dwell counter, request capture and registered divider controls
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            cap_sel    <= 2'b00;
            cap_bypass <= 1'b0;
            div_enable <= 1'b0;
            div_sel    <= DEFAULT_SEL;
            div_bypass <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= (next_state != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
            div_enable <= run && (next_state == IDLE || next_state == RESUME);
            done       <= (state == RESUME && next_state == IDLE) || (accept && same);
            if (accept) begin
                cap_sel    <= req_sel;
                cap_bypass <= req_bypass;
            end
            if (state == UPDATE) begin
                div_sel    <= cap_sel;
                div_bypass <= cap_bypass;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed plus random checks of clk_div_ctrl against a timeline model.
module tb_clk_div_ctrl;
    localparam int S = 4;
    localparam int L = 16;
    localparam logic [1:0] DEF = 2'b00;
`ifdef CLK_DIV_CTRL_SAME_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic req_valid = 1'b0;
    logic [1:0] req_sel = 2'b00;
    logic req_bypass = 1'b0;
    logic req_ready, div_enable, div_bypass, busy, done;
    logic [1:0] div_sel;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model: a sequence is a window of cycles measured from its acceptance cycle
    bit m_active = 0;
    int m_acc = 0;
    logic [1:0] m_sel = DEF, m_psel = 2'b00;
    logic m_byp = 0, m_pbyp = 0, m_en = 0, m_done = 0;

    clk_div_ctrl #(.SETTLE_CYCLES(S), .LOCK_CYCLES(L), .DEFAULT_SEL(DEF)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .run(run), .req_valid(req_valid),
        .req_ready(req_ready), .req_sel(req_sel), .req_bypass(req_bypass),
        .div_enable(div_enable), .div_sel(div_sel), .div_bypass(div_bypass),
        .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        check("req_ready", 8'(req_ready), 8'(!m_active));
        check("busy", 8'(busy), 8'(m_active));
        check("done", 8'(done), 8'(m_done));
        check("div_enable", 8'(div_enable), 8'(m_en));
        check("div_sel", 8'(div_sel), 8'(m_sel));
        check("div_bypass", 8'(div_bypass), 8'(m_byp));
    endtask

    task automatic model_reset();
        m_active = 0; m_sel = DEF; m_byp = 0; m_en = 0; m_done = 0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
    endtask

    task automatic tick(input logic r, input logic v, input logic [1:0] s, input logic b);
        logic acc_now;
        int e;
        run = r; req_valid = v; req_sel = s; req_bypass = b;
        acc_now = v && !m_active;
        @(posedge clk_in);
        #1;
        cyc++;
        m_done = 0;
        if (acc_now) begin
            if (SKIP && s == m_sel && b == m_byp) m_done = 1;
            else begin m_active = 1; m_acc = cyc - 1; m_psel = s; m_pbyp = b; end
        end
        e = cyc - m_acc;
        if (m_active && e == S + 2) begin m_sel = m_psel; m_byp = m_pbyp; end
        if (m_active && e == S + L + 2) begin m_done = 1; m_active = 0; end
        m_en = r && !(m_active && e <= S + 1);
        check_all();
    endtask

    initial begin
        #3;
        model_reset();
        check_all();
        #4 rst_n = 1'b1;
        // enable follows run one cycle later, sel=10 request
        tick(1, 0, 2'b00, 0);
        tick(1, 1, 2'b10, 0);
        repeat (22) tick(1, 0, 2'b00, 0);
        // request held through busy is accepted in the done cycle
        tick(1, 1, 2'b01, 1);
        repeat (22) tick(1, 1, 2'b11, 0);
        repeat (23) tick(1, 0, 2'b00, 0);
        // run low for a whole request
        tick(0, 1, 2'b01, 1);
        repeat (23) tick(0, 0, 2'b00, 0);
        // reset during RESUME abandons the request
        tick(1, 1, 2'b10, 1);
        repeat (10) tick(1, 0, 2'b00, 0);
        reset_pulse();
        repeat (3) tick(1, 0, 2'b00, 0);
        // request equal to current config
        tick(1, 1, DEF, 0);
        repeat (23) tick(1, 0, 2'b00, 0);
        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
                 2'($urandom), 1'($urandom));
            if ($urandom_range(0, 199) == 0) reset_pulse();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SETTLE_CYCLES, 4, divider-disabled hold time in clk_in cycles before config update; legal 1..255.
REQ-002 LOCK_CYCLES, 16, post-enable wait in clk_in cycles before completion is reported; legal 1..255.
REQ-003 DEFAULT_SEL, 2'b00, div_sel value loaded at reset.
REQ-004 clk_in  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 run  input  1  global divider run request; 0 forces div_enable low.
REQ-007 req_valid  input  1  reconfiguration request valid.
REQ-008 req_ready  output  1  controller can accept a request (high only in IDLE).
REQ-009 req_sel  input  2  requested division select (00=/2, 01=/4, 10=/8, 11=/16).
REQ-010 req_bypass  input  1  requested bypass setting.
REQ-011 div_enable  output  1  registered enable to divider.
REQ-012 div_sel  output  2  registered division select to divider.
REQ-013 div_bypass  output  1  registered bypass to divider.
REQ-014 busy  output  1  high in DRAIN, UPDATE and RESUME.
REQ-015 done  output  1  one-cycle pulse on completion of a reconfiguration.

Function
REQ-016 Request SHALL be accepted on a clk_in rising edge where req_valid and req_ready are both high; req_sel/req_bypass SHALL be captured into a holding register on that edge.
REQ-017 FSM states SHALL be IDLE, DRAIN, UPDATE, RESUME; IDLE->DRAIN on accept, DRAIN->UPDATE after exactly SETTLE_CYCLES cycles in DRAIN, UPDATE->RESUME after exactly 1 cycle, RESUME->IDLE after exactly LOCK_CYCLES cycles in RESUME.
REQ-018 div_enable SHALL be registered: next value = run when next state is IDLE or RESUME, else 0.
REQ-019 div_sel/div_bypass SHALL change only on the edge leaving UPDATE, loading the captured values; they SHALL be stable in every other state.
REQ-020 done SHALL pulse high for exactly one cycle, the first IDLE cycle after RESUME; with defaults and acceptance in cycle 0: DRAIN cycles 1-4, UPDATE 5, RESUME 6-21, done in cycle 22.
REQ-021 A new request SHALL be acceptable in the same cycle done is high.
REQ-022 req_valid while req_ready low SHALL be ignored (no capture); requester holds until accepted.
REQ-023 run deasserted mid-sequence SHALL not stall the FSM; it only forces div_enable low; sequence timing is unchanged.
REQ-024 Cycle counter SHALL be 8 bits, cleared on each state entry, no wrap-around reachable for legal parameters.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, counter=0, div_enable=0, div_sel=DEFAULT_SEL, div_bypass=0, done=0, busy=0; holding register cleared.
REQ-026 Reset asserted mid-sequence SHALL abandon the request with no done pulse; first cycle after release is IDLE with req_ready=1.
REQ-027 After release, div_enable SHALL follow run with one-cycle latency.

Configuration
REQ-028 Macro CLK_DIV_CTRL_SAME_SKIP_EN defined: an accepted request whose req_sel and req_bypass equal current div_sel and div_bypass SHALL skip DRAIN/UPDATE/RESUME, stay IDLE, and pulse done in the cycle after acceptance with div_enable unaffected.
REQ-029 Macro undefined: every accepted request SHALL run the full sequence of REQ-017 regardless of value.

Verification
REQ-030 Reset, run=1, request sel=10 bypass=0 at cycle 0 -> div_enable low cycles 1-5, div_sel=10 from cycle 6, div_enable high from cycle 6, done only in cycle 22, busy high cycles 1-21.
REQ-031 req_valid held high during busy with sel=11 -> not accepted until done cycle; accepted then, second done exactly 22 cycles later.
REQ-032 rst_n pulsed low in RESUME cycle 10 -> outputs immediately at reset values, no done, div_sel=DEFAULT_SEL.
REQ-033 run=0 throughout a request -> div_enable 0 every cycle, done still in cycle 22.
REQ-034 Request equal to current config (sel=00, bypass=0 after reset) -> with CLK_DIV_CTRL_SAME_SKIP_EN done in cycle 1, busy never high; without it done in cycle 22.
REQ-035 Bypass request sel=01 bypass=1 -> div_bypass rises at cycle 6 edge only, never during DRAIN.
